// File: rtl/rv0_core_pkg.sv
// rv0 core shared types and constants.
// FP op encoding, rounding modes, FIQ entry layout.
package rv0_core_pkg;

  localparam int unsigned CORE_FLEN = 32;

  typedef enum logic [3:0] {
    FADD   = 4'd0,
    FSUB   = 4'd1,
    FMUL   = 4'd2,
    FDIV   = 4'd3,
    FSQRT  = 4'd4,
    FMIN   = 4'd5,
    FMAX   = 4'd6,
    FMADD  = 4'd7,
    FMSUB  = 4'd8,
    FNMADD = 4'd9,
    FNMSUB = 4'd10,
    FSGNJ  = 4'd11,
    FCMP   = 4'd12,
    FCVT   = 4'd13,
    FMV    = 4'd14,
    FCLASS = 4'd15
  } fpu_op_t;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
  localparam logic [2:0] DYN = 3'b111;

  typedef struct packed {
    fpu_op_t                op;
    logic [2:0]             rm;
    logic                   illegal;
    logic [4:0]             rd;
    logic [CORE_FLEN-1:0]   rs1;
    logic [CORE_FLEN-1:0]   rs2;
    logic [CORE_FLEN-1:0]   rs3;
  } fiq_entry_t;

  // 101, 110 and 111 have no defined rounding behaviour
  function automatic logic rm_reserved(input logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
  endfunction

endpackage

// File: rtl/rv0_fiq.sv
// rv0 FP issue queue: in-order FIFO between operand read
// and the FP ALU, resolving DYN rounding at enqueue.
module rv0_fiq
  import rv0_core_pkg::*;
#(
  parameter int unsigned FLEN      = CORE_FLEN,
  parameter int unsigned FIQ_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [2:0]                     frm,
  input  logic                           enq_valid,
  output logic                           enq_ready,
  input  fpu_op_t                        enq_op,
  input  logic [2:0]                     enq_rm,
  input  logic [4:0]                     enq_rd,
  input  logic [FLEN-1:0]                enq_rs1,
  input  logic [FLEN-1:0]                enq_rs2,
  input  logic [FLEN-1:0]                enq_rs3,
  output logic                           deq_valid,
  input  logic                           deq_ready,
  output fpu_op_t                        deq_op,
  output logic [2:0]                     deq_rm,
  output logic [4:0]                     deq_rd,
  output logic [FLEN-1:0]                deq_rs1,
  output logic [FLEN-1:0]                deq_rs2,
  output logic [FLEN-1:0]                deq_rs3,
  output logic                           deq_illegal,
  output logic [$clog2(FIQ_DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(FIQ_DEPTH+1);
  localparam int unsigned PW = $clog2(FIQ_DEPTH);

  fiq_entry_t      mem [FIQ_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_enq;
  logic            do_deq;
  fiq_entry_t      new_ent;
  fiq_entry_t      head;

  assign enq_ready = (count < CW'(FIQ_DEPTH)) && !flush;
  assign deq_valid = (count != '0);
  assign do_enq    = enq_valid && enq_ready;
  assign do_deq    = deq_valid && deq_ready;

  // build the entry, resolving DYN to the live frm
  always_comb begin
    new_ent         = '0;
    new_ent.op      = enq_op;
    new_ent.rm      = (enq_rm == DYN) ? frm : enq_rm;
    new_ent.illegal = rm_reserved(new_ent.rm);
    new_ent.rd      = enq_rd;
    new_ent.rs1     = enq_rs1;
    new_ent.rs2     = enq_rs2;
    new_ent.rs3     = enq_rs3;
  end

  // storage is never cleared; pointers alone define validity
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= new_ent;
  end

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PW'(1);
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // head payload, forced to zero while empty
  always_comb begin
    head = deq_valid ? mem[rd_ptr] : '0;
  end

  assign deq_op      = head.op;
  assign deq_rm      = head.rm;
  assign deq_illegal = head.illegal;
  assign deq_rd      = head.rd;
  assign deq_rs1     = head.rs1;
  assign deq_rs2     = head.rs2;
  assign deq_rs3     = head.rs3;

endmodule

// File: tb/tb_rv0_fiq.sv
// rv0_fiq bench: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_rv0_fiq;
  import rv0_core_pkg::*;

  localparam int DEPTH = 4;
  localparam int FL    = 32;

  logic          clk = 1'b0;
  logic          rst, flush, enq_valid, deq_ready;
  logic [2:0]    frm, enq_rm;
  logic [4:0]    enq_rd;
  logic [FL-1:0] enq_rs1, enq_rs2, enq_rs3;
  fpu_op_t       enq_op;
  logic          enq_ready, deq_valid, deq_illegal;
  fpu_op_t       deq_op;
  logic [2:0]    deq_rm;
  logic [4:0]    deq_rd;
  logic [FL-1:0] deq_rs1, deq_rs2, deq_rs3;
  logic [2:0]    count;

  int n_vec = 0;
  int n_bad = 0;
  bit known = 0;

  logic [108:0] q[$];

  always #5 clk = ~clk;

  rv0_fiq #(.FLEN(FL), .FIQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .frm(frm),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_op(enq_op), .enq_rm(enq_rm), .enq_rd(enq_rd),
    .enq_rs1(enq_rs1), .enq_rs2(enq_rs2), .enq_rs3(enq_rs3),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_op(deq_op), .deq_rm(deq_rm), .deq_rd(deq_rd),
    .deq_rs1(deq_rs1), .deq_rs2(deq_rs2), .deq_rs3(deq_rs3),
    .deq_illegal(deq_illegal), .count(count)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit f,
                      input bit ev, input bit dr,
                      input logic [2:0] rm,
                      input logic [4:0] rd,
                      input logic [2:0] fr);
    logic [2:0]   res_rm;
    logic [108:0] ent, head;
    bit           rdy, de, dd;
    @(negedge clk);
    rst       = r;
    flush     = f;
    enq_valid = ev;
    deq_ready = dr;
    enq_rm    = rm;
    enq_rd    = rd;
    frm       = fr;
    enq_op    = fpu_op_t'(4'($urandom_range(0, 15)));
    enq_rs1   = $urandom;
    enq_rs2   = $urandom;
    enq_rs3   = $urandom;
    #1;
    rdy = (q.size() < DEPTH) && !f;
    de  = ev && rdy;
    dd  = (q.size() > 0) && dr;
    if (known) begin
      head = (q.size() > 0) ? q[0] : '0;
      chk("count", 128'(count), 128'(q.size()));
      chk("deq_valid", 128'(deq_valid), 128'(q.size() > 0));
      chk("enq_ready", 128'(enq_ready), 128'(rdy));
      chk("payload",
          128'({deq_op, deq_rm, deq_illegal, deq_rd,
                deq_rs1, deq_rs2, deq_rs3}),
          128'(head));
    end
    res_rm = (rm == 3'd7) ? fr : rm;
    ent = {4'(enq_op), res_rm, (res_rm >= 3'd5), rd,
           enq_rs1, enq_rs2, enq_rs3};
    @(posedge clk);
    if (r) known = 1;
    if (r || f) begin
      q.delete();
    end else begin
      if (dd) void'(q.pop_front());
      if (de) q.push_back(ent);
    end
  endtask

  initial begin
    rst = 1; flush = 0; enq_valid = 0; deq_ready = 0;
    frm = 0; enq_rm = 0; enq_rd = 0; enq_op = FADD;
    enq_rs1 = 0; enq_rs2 = 0; enq_rs3 = 0;

    step(1, 0, 0, 0, 3'd0, 5'd0, 3'd0);
    step(1, 0, 0, 0, 3'd0, 5'd0, 3'd0);

    // fill to full with no drain, then hold
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 0, 3'(i), 5'(i + 1), 3'd0);
    step(0, 0, 1, 0, 3'd0, 5'd31, 3'd0);
    step(0, 0, 1, 1, 3'd0, 5'd30, 3'd0);
    step(0, 0, 0, 0, 3'd0, 5'd0, 3'd0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 1, 3'd0, 5'd0, 3'd0);

    // no bypass on empty queue
    step(0, 0, 1, 1, 3'd0, 5'd5, 3'd0);
    step(0, 0, 0, 1, 3'd0, 5'd0, 3'd0);
    step(0, 0, 0, 1, 3'd0, 5'd0, 3'd0);

    // steady enq/deq at count 2 across wrap
    step(0, 0, 1, 0, 3'd1, 5'd10, 3'd0);
    step(0, 0, 1, 0, 3'd2, 5'd11, 3'd0);
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 1, 3'd3, 5'(12 + i), 3'd0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 3'd0, 5'd0, 3'd0);

    // DYN resolution, legal and reserved
    step(0, 0, 1, 0, 3'd7, 5'd1, 3'd1);
    step(0, 0, 1, 0, 3'd7, 5'd2, 3'd6);
    step(0, 0, 1, 0, 3'd5, 5'd3, 3'd0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 1, 3'd0, 5'd0, 3'd2);

    // flush at count 3 with a concurrent enqueue
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, 3'd0, 5'(20 + i), 3'd0);
    step(0, 1, 1, 1, 3'd0, 5'd29, 3'd0);
    step(0, 0, 0, 1, 3'd0, 5'd0, 3'd0);
    step(0, 0, 0, 1, 3'd0, 5'd0, 3'd0);

    // reset mid-operation at count 2
    step(0, 0, 1, 0, 3'd0, 5'd7, 3'd0);
    step(0, 0, 1, 0, 3'd0, 5'd8, 3'd0);
    step(1, 0, 1, 1, 3'd0, 5'd9, 3'd0);
    step(0, 0, 0, 1, 3'd0, 5'd0, 3'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)),
           3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rv0_fiq.md
RV0_FIQ -- requirements
Module: rv0_fiq

Interface
REQ-001 Parameters SHALL be the core's shared parameter list, plus FIQ_DEPTH (default 4, power of two, >=2): number of queue entries.
REQ-002 FLEN (from the core parameter list) SHALL set the floating-point operand width (32 for F).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  core clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 flush  in  1  pipeline flush; discards all entries.
REQ-007 frm  in  3  fcsr.frm, the dynamic rounding mode.
REQ-008 enq_valid  in  1; enq_ready  out  1  upstream (decode/operand-read) handshake.
REQ-009 enq_op  in  fpu_op_t  FP ALU operation; enq_rm  in  3  instruction rm field; enq_rd  in  5  destination register.
REQ-010 enq_rs1, enq_rs2, enq_rs3  in  FLEN each  source operand values.
REQ-011 deq_valid  out  1; deq_ready  in  1  handshake with the downstream FP ALU.
REQ-012 deq_op, deq_rm (3, resolved), deq_rd (5), deq_rs1/2/3 (FLEN)  out  head-entry payload.
REQ-013 deq_illegal  out  1  the head entry's resolved rounding mode is reserved.
REQ-014 count  out  $clog2(FIQ_DEPTH+1)  current occupancy.

Function
REQ-015 Ordering: in-order FIFO; an enqueue occurs when enq_valid && enq_ready, a dequeue when deq_valid && deq_ready.
REQ-016 Readiness: enq_ready = (count < FIQ_DEPTH) && !flush, with no combinational path from deq_ready; a full queue refuses an enqueue even when a dequeue occurs in the same cycle.
REQ-017 deq_valid = (count != 0); deq_valid and payload SHALL be derived from state only.
REQ-018 Latency: an entry enqueued in cycle N SHALL appear at the head no earlier than cycle N+1; there is no bypass, including when the queue is empty.
REQ-019 Stability: while deq_valid=1 && deq_ready=0, all deq_* outputs SHALL hold stable.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-021 Pointers: read and write pointers are log2(FIQ_DEPTH) bits and wrap from FIQ_DEPTH-1 to 0.
REQ-022 Rounding-mode resolution at enqueue: if enq_rm==3'b111 (DYN), store frm; otherwise store enq_rm.
REQ-023 Illegal rounding mode: a stored rm of 3'b101, 3'b110 or 3'b111 SHALL set that entry's illegal bit; the entry is queued and delivered normally.
REQ-024 Payload when empty: deq_op, deq_rm, deq_rd, deq_rs1/2/3 and deq_illegal SHALL be driven to zero when deq_valid=0.
REQ-025 Flush: flush=1 SHALL, at the next edge, set count=0 and both pointers to 0; an enqueue or dequeue in the flush cycle has no effect; deq_valid=0 from the following cycle.
REQ-026 Precedence: rst takes priority over flush.
REQ-027 No other state SHALL exist; storage contents are not cleared by rst or flush.

Reset
REQ-028 On rst=1 at a clock edge: count=0, pointers=0, deq_valid=0, all deq_* payload=0 and deq_illegal=0.
REQ-029 enq_ready SHALL be 1 in the first cycle after reset deasserts (when flush=0).
REQ-030 Reset asserted mid-operation SHALL discard all entries identically to REQ-028, regardless of any handshakes in that cycle.

Structure
REQ-031 rv0_core_pkg SHALL hold: fpu_op_t enum, rounding-mode constants (RNE, RTZ, RDN, RUP, RMM, DYN), and fiq_entry_t struct (op, rm, illegal, rd, rs1, rs2, rs3).
REQ-032 Storage SHALL be a single array of fiq_entry_t inside rv0_fiq; rounding-mode resolution is inline logic and no sub-module is required.

Verification
REQ-033 Reset then 4 enqueues with deq_ready=0 (FIQ_DEPTH=4) -> enq_ready=0 after the 4th, count=4, head = first entry, payload held stable.
REQ-034 Empty queue, enqueue rd=5 in cycle N with deq_ready=1 -> deq_valid=0 in N, deq_valid=1 with deq_rd=5 in N+1, dequeued, count=0 in N+2.
REQ-035 Steady concurrent enq/deq for 10 cycles at count=2 -> count stays 2, output order equals input order across pointer wrap.
REQ-036 enq_rm=3'b111 with frm=3'b001 -> deq_rm=3'b001, deq_illegal=0; enq_rm=3'b111 with frm=3'b110 -> deq_rm=3'b110, deq_illegal=1.
REQ-037 count=3, flush=1 together with enq_valid=1 -> next cycle count=0, deq_valid=0, enq_ready=1; the flushed enqueue never appears at the output.
REQ-038 count=2, rst=1 with deq_ready=1 -> next cycle count=0, all deq_* outputs = 0.
